// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
//
// Serial receive front-end for the TinyQV UART peripheral. Synchronises the
// raw RXD pin, detects start bits, samples 8 data bits LSB-first at mid-bit,
// checks the stop bit and presents each byte on a valid/read handshake.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : every start/data/stop bit is a 2-of-3 majority vote of rxd_s
//               taken at counter values 1, 0 and div_q-1. The decision is
//               applied one cycle after the counter-0 event, so valid and
//               frame_err appear one cycle later than in the default build.
//   undefined : single sample of rxd_s when the counter reaches 0.
//
// Ports:
//   clk                project clock (64 MHz nominal)
//   rst                synchronous, active-high reset
//   baud_divider       clock cycles per bit (values below 4 behave as 4)
//   uart_rxd           raw serial input, idle high, asynchronous to clk
//   uart_rx_read       consumer accepts the byte (only while valid is high)
//   uart_rx_valid      byte available on uart_rx_data
//   uart_rx_data       received byte, stable while uart_rx_valid is high
//   uart_rx_frame_err  one-cycle pulse: stop bit sampled low
//   uart_rx_overrun    one-cycle pulse: byte completed over an unread byte
//   uart_rts           high while an unread byte is held (equals valid)
//   dbg_state          current receiver FSM state (debug observation)
//
// Handshake: uart_rx_valid rises when a byte completes and stays high until a
// cycle with uart_rx_read=1 while valid=1; valid then falls on the next edge
// unless a new byte completes on that same edge, in which case the new byte
// is loaded and valid stays high. uart_rx_read while valid=0 is ignored.
// ----------------------------------------------------------------------------
module uart_rx_sampler #(
   parameter int DIVIDER_REG_LEN = 13
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DIVIDER_REG_LEN-1:0] baud_divider,
   input  logic                       uart_rxd,
   input  logic                       uart_rx_read,
   output logic                       uart_rx_valid,
   output logic [7:0]                 uart_rx_data,
   output logic                       uart_rx_frame_err,
   output logic                       uart_rx_overrun,
   output logic                       uart_rts,
   output logic [2:0]                 dbg_state
);

   localparam int W = DIVIDER_REG_LEN;
   localparam logic [W-1:0] DIV_MIN = W'(4);
   localparam logic [W-1:0] ONE     = W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t       state, state_next;
   logic         rxd_m, rxd_s;
   logic [W-1:0] div_eff, div_q, cnt;
   logic [2:0]   bit_idx;
   logic [7:0]   shreg;

   logic         sample_evt;  // counter hit 0 inside a frame
   logic         bit_evt;     // a bit decision is available this cycle
   logic         bit_val;     // the decided bit value
   logic         start_det, shift_en, byte_done, frame_bad;

   // Divider clamp: below 4 the half-bit start offset gets too small to work.
   assign div_eff = (baud_divider < DIV_MIN) ? DIV_MIN : baud_divider;

   assign sample_evt = (state == ST_START || state == ST_DATA || state == ST_STOP)
                       && (cnt == '0);

   // Two-flop synchroniser; everything downstream looks only at rxd_s.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= uart_rxd;
         rxd_s <= rxd_m;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Votes at cnt==1 and cnt==0 are stored; the third vote is the live rxd_s
   // in the cycle after the counter-0 event (cnt==div_q-1), which is when the
   // decision is applied.
   logic vote_1, vote_0, vote_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         vote_1    <= 1'b1;
         vote_0    <= 1'b1;
         vote_pend <= 1'b0;
      end else begin
         vote_pend <= sample_evt;
         if (cnt == ONE) vote_1 <= rxd_s;
         if (cnt == '0)  vote_0 <= rxd_s;
      end
   end

   assign bit_evt = vote_pend;
   assign bit_val = (vote_1 & vote_0) | (vote_1 & rxd_s) | (vote_0 & rxd_s);
`else
   assign bit_evt = sample_evt;
   assign bit_val = rxd_s;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // FSM next-state and control strobes
   always_comb begin
      state_next = state;
      start_det  = 1'b0;
      shift_en   = 1'b0;
      byte_done  = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rxd_s) begin
               start_det  = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (bit_evt) state_next = bit_val ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (bit_evt) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_evt) begin
               if (bit_val) begin
                  byte_done  = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  frame_bad  = 1'b1;
                  state_next = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // Hold here until the line returns high so a stuck-low line
            // reports one framing error rather than a stream of frames.
            if (rxd_s) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Bit timer, divider latch, bit index and shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= DIV_MIN;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (start_det) begin
            div_q <= div_eff;
            cnt   <= div_eff >> 1;
         end else if (sample_evt) begin
            cnt <= div_q - ONE;
         end else if (cnt != '0) begin
            cnt <= cnt - ONE;
         end

         if (state == ST_START && bit_evt) bit_idx <= 3'd0;
         else if (shift_en)                bit_idx <= bit_idx + 3'd1;

         if (shift_en) shreg <= {bit_val, shreg[7:1]};
      end
   end

   // Output holding register and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         uart_rx_valid     <= 1'b0;
         uart_rx_data      <= 8'h00;
         uart_rx_frame_err <= 1'b0;
         uart_rx_overrun   <= 1'b0;
      end else begin
         uart_rx_frame_err <= frame_bad;
         uart_rx_overrun   <= byte_done && uart_rx_valid && !uart_rx_read;
         if (byte_done) begin
            uart_rx_valid <= 1'b1;
            uart_rx_data  <= shreg;
         end else if (uart_rx_read && uart_rx_valid) begin
            uart_rx_valid <= 1'b0;
         end
      end
   end

   assign uart_rts  = uart_rx_valid;
   assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Directed and randomized bench for uart_rx_sampler. Frames are generated
// bit-by-bit on uart_rxd at a chosen number of cycles per bit. The reference
// model is a queue of bytes the line carried with a good stop bit plus
// running totals of expected framing errors and overruns.
// ----------------------------------------------------------------------------
module tb_uart_rx_sampler;

   logic        clk;
   logic        rst;
   logic [12:0] baud_divider;
   logic        uart_rxd;
   logic        uart_rx_read;
   logic        uart_rx_valid;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_frame_err;
   logic        uart_rx_overrun;
   logic        uart_rts;
   logic [2:0]  dbg_state;

   uart_rx_sampler #(.DIVIDER_REG_LEN(13)) dut (
      .clk               (clk),
      .rst               (rst),
      .baud_divider      (baud_divider),
      .uart_rxd          (uart_rxd),
      .uart_rx_read      (uart_rx_read),
      .uart_rx_valid     (uart_rx_valid),
      .uart_rx_data      (uart_rx_data),
      .uart_rx_frame_err (uart_rx_frame_err),
      .uart_rx_overrun   (uart_rx_overrun),
      .uart_rts          (uart_rts),
      .dbg_state         (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int exp_fe  = 0;
   int exp_ov  = 0;

   // Monitors, sampled on the falling edge
   int fe_cnt = 0;
   int ov_cnt = 0;
   int rts_bad = 0;
   int state_bad = 0;
   bit watch_state = 1'b0;

   always @(negedge clk) begin
      if (uart_rx_frame_err === 1'b1) fe_cnt++;
      if (uart_rx_overrun === 1'b1)   ov_cnt++;
      if (!rst && (uart_rts !== uart_rx_valid)) rts_bad++;
      if (watch_state && (dbg_state !== 3'd0) && (dbg_state !== 3'd1)) state_bad++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame; optionally flip one cycle of one bit (bit 0 = start,
   // 1..8 = data, 9 = stop) and optionally stop after max_cyc cycles.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int div,
                             input int glitch_bit, input int glitch_cyc, input int max_cyc);
      logic [9:0] fr;
      logic       v;
      int         n;
      fr = {stop, d, 1'b0};
      n  = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < div; c++) begin
            if (n == max_cyc) return;
            v = fr[i];
            if (i == glitch_bit && c == glitch_cyc) v = ~v;
            uart_rxd = v;
            cyc(1);
            n++;
         end
      end
   endtask

   task automatic send_good(input logic [7:0] d, input int div);
      exp_q.push_back(d);
      send_frame(d, 1'b1, div, -1, 0, 1000000);
   endtask

   // Wait for valid, compare against the model, then pulse read and check
   // that valid/rts drop on the following edge.
   task automatic read_byte(input string tag, input int budget);
      int         k;
      logic [31:0] exp;
      k = 0;
      @(negedge clk);
      while (uart_rx_valid !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_valid"}, 32'(uart_rx_valid), 32'd1);
      if (uart_rx_valid === 1'b1) begin
         exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
         check({tag, "_data"}, 32'(uart_rx_data), exp);
         check({tag, "_rts"}, 32'(uart_rts), 32'd1);
         @(posedge clk);
         #1 uart_rx_read = 1'b1;
         @(posedge clk);
         #1 uart_rx_read = 1'b0;
         @(negedge clk);
         check({tag, "_valid_clr"}, 32'(uart_rx_valid), 32'd0);
         check({tag, "_rts_clr"}, 32'(uart_rts), 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int fe0, ov0, div;
      logic [7:0] d;

      rst          = 1'b1;
      baud_divider = 13'd16;
      uart_rxd     = 1'b1;
      uart_rx_read = 1'b0;
      cyc(3);

      // Reset state
      check("rst_valid", 32'(uart_rx_valid), 32'd0);
      check("rst_data", 32'(uart_rx_data), 32'h00);
      check("rst_fe", 32'(uart_rx_frame_err), 32'd0);
      check("rst_ov", 32'(uart_rx_overrun), 32'd0);
      check("rst_rts", 32'(uart_rts), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      cyc(20);

      // Single byte 0x55 at divider 16
      send_good(8'h55, 16);
      cyc(5);
      check("t55_rts_hold", 32'(uart_rts), 32'd1);
      read_byte("t55", 400);

      // Back-to-back 0xA3 then 0x3C, consumer reading concurrently
      ov0 = ov_cnt;
      fork
         begin
            send_good(8'hA3, 16);
            send_good(8'h3C, 16);
         end
         begin
            read_byte("b2b_a3", 400);
            read_byte("b2b_3c", 400);
         end
      join
      check("b2b_no_ov", 32'(ov_cnt - ov0), 32'd0);
      cyc(10);

      // Two bytes without reading: second overwrites, one overrun pulse
      ov0 = ov_cnt;
      send_good(8'h11, 16);
      send_good(8'h22, 16);
      void'(exp_q.pop_front());
      exp_ov++;
      cyc(2);
      check("ovr_valid", 32'(uart_rx_valid), 32'd1);
      check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
      read_byte("ovr_22", 400);

      // Bad stop then line held low for 40 bits: exactly one framing error
      fe0 = fe_cnt;
      send_frame(8'h7E, 1'b0, 16, -1, 0, 1000000);
      exp_fe++;
      cyc(40 * 16);
      uart_rxd = 1'b1;
      cyc(3 * 16);
      check("brk_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("brk_valid", 32'(uart_rx_valid), 32'd0);
      send_good(8'h81, 16);
      read_byte("brk_81", 400);

      // Three-cycle low glitch on an idle line
      fe0 = fe_cnt;
      watch_state = 1'b1;
      uart_rxd = 1'b0;
      cyc(3);
      uart_rxd = 1'b1;
      cyc(3 * 16);
      watch_state = 1'b0;
      check("glitch_state", 32'(state_bad), 32'd0);
      check("glitch_valid", 32'(uart_rx_valid), 32'd0);
      check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

`ifdef UART_RX_MAJORITY_EN
      // One-cycle glitch at the sample point of data bit 5 is outvoted
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b1, 16, 6, 9, 1000000);
      read_byte("maj_f0", 400);
`endif

      // Reset during data bit 4 of 0xC5, with an unread byte pending
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_good(8'h33, 16);
      cyc(4);
      check("prerst_valid", 32'(uart_rx_valid), 32'd1);
      send_frame(8'hC5, 1'b1, 16, -1, 0, 16 * 5 + 8);
      rst = 1'b1;
      uart_rxd = 1'b1;
      cyc(1);
      exp_q.delete();
      check("midrst_valid", 32'(uart_rx_valid), 32'd0);
      check("midrst_data", 32'(uart_rx_data), 32'h00);
      check("midrst_rts", 32'(uart_rts), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      cyc(32);
      check("postrst_valid", 32'(uart_rx_valid), 32'd0);
      check("postrst_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

      // 0x5A at 16 with baud_divider changed to 8 mid-frame
      fork
         send_good(8'h5A, 16);
         begin
            cyc(40);
            baud_divider = 13'd8;
         end
      join
      read_byte("divchg_5a", 400);
      baud_divider = 13'd16;

      // Divider below the minimum behaves as 4 cycles per bit
      baud_divider = 13'd2;
      send_good(8'h96, 4);
      read_byte("clamp_96", 200);

      // Randomized frames: random byte, divider, occasional bad stop bit
      for (int i = 0; i < 16; i++) begin
         d   = 8'($urandom_range(0, 255));
         div = $urandom_range(5, 40);
         baud_divider = 13'(div);
         if ($urandom_range(0, 5) == 0) begin
            send_frame(d, 1'b0, div, -1, 0, 1000000);
            exp_fe++;
            uart_rxd = 1'b1;
            cyc(2 * div);
            check("rnd_bad_valid", 32'(uart_rx_valid), 32'd0);
         end else begin
            send_good(d, div);
            read_byte("rnd", 12 * div + 50);
         end
         cyc($urandom_range(0, 20));
      end

      // Totals against the model
      cyc(10);
      check("tot_frame_err", 32'(fe_cnt), 32'(exp_fe));
      check("tot_overrun", 32'(ov_cnt), 32'(exp_ov));
      check("tot_rts_eq_valid", 32'(rts_bad), 32'd0);
      check("tot_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #5000000;
      n_fail++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial receive front-end for the TinyQV UART peripheral. Feeds the wrapper's one-byte RX buffer.
- Takes the raw RXD pin, synchronises it, detects start bits, samples 8 data bits LSB-first at mid-bit and checks the stop bit.
- Presents each byte on a valid/read handshake, with framing-error, overrun and RTS flow-control outputs.

Parameters:
DIVIDER_REG_LEN, 13, width of baud_divider (clock cycles per bit); 13 bits covers 9600 baud at 64 MHz.

Ports:
clk  input  1  project clock (64 MHz nominal)
rst  input  1  synchronous, active-high reset
baud_divider  input  DIVIDER_REG_LEN  clock cycles per bit period
uart_rxd  input  1  raw serial input, idle high, asynchronous to clk
uart_rx_read  input  1  consumer accepts byte; honoured only while uart_rx_valid=1
uart_rx_valid  output  1  byte available on uart_rx_data
uart_rx_data  output  8  received byte; stable while uart_rx_valid=1
uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
uart_rx_overrun  output  1  one-cycle pulse: byte completed while previous byte still unread
uart_rts  output  1  high = receiver holding an unread byte (request sender to pause); equals uart_rx_valid

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; sync flops=1; bit counter=0; shift reg=0.
  - uart_rx_valid=0, uart_rx_data=0x00, uart_rx_frame_err=0, uart_rx_overrun=0, uart_rts=0.
  - Reset mid-frame abandons the frame; no valid or error pulse is produced.
- Synchroniser: two flops on uart_rxd. rxd_s is the second flop. All decisions use rxd_s, so there is 2 cycles of pin latency.
- Divider latch:
  - baud_divider is captured into div_q on start detection and held for the whole frame. Register writes mid-frame do not affect the frame in progress.
  - Effective divider = max(baud_divider, 4).
- Timer: down-counter. A sample event occurs on the cycle the counter equals 0, and the counter reloads in that same cycle.
- FSM:
  - IDLE: when rxd_s=0, load counter = div_q>>1, go to START.
  - START: on sample event, if rxd_s=1 (glitch) go to IDLE with no output. Otherwise load counter = div_q-1, set bit_idx=0, go to DATA.
  - DATA: on each sample event, shift rxd_s into bit 7 of the shift register (LSB-first) and reload div_q-1. When bit_idx=7 is sampled, go to STOP.
  - STOP, on sample event, stop=1:
    - Load uart_rx_data from the shift reg and set uart_rx_valid=1 on the next edge.
    - If uart_rx_valid was already 1 and uart_rx_read was not asserted that cycle, overwrite the data and pulse uart_rx_overrun.
    - Go to IDLE.
  - STOP, on sample event, stop=0: pulse uart_rx_frame_err, discard the byte (valid and data unchanged), go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. A held-low line therefore yields exactly one frame_err, not repeated frames.
- Handshake:
  - uart_rx_read=1 while uart_rx_valid=1 clears valid on the next edge.
  - Read and byte completion in the same cycle: the new byte is loaded, valid stays 1, no overrun pulse.
  - uart_rx_read while valid=0 is ignored.
- Latency: from the stop-bit sample event to uart_rx_valid=1 is 1 cycle.
- Back-to-back frames: a start bit immediately after the stop sample is detected. IDLE is re-entered in the same cycle the stop bit is sampled, at mid-stop, leaving half a bit of margin.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each start, data and stop bit is decided by a 2-of-3 majority vote of rxd_s taken at counter values 1, 0 and div_q-1 (the first cycle after reload). The decision and shift are applied one cycle after the counter-0 event. The valid/frame_err timing therefore shifts by +1 cycle.
- Undefined: a single sample at counter=0, as described above.

Test Plan:
- div=16, send 0x55 (8N1) -> uart_rx_valid rises once, uart_rx_data=0x55, frame_err=0, uart_rts=1 until uart_rx_read is pulsed, then valid=0 and rts=0 the next cycle.
- div=16, send 0xA3 then 0x3C back-to-back with no idle gap, read each on valid -> 0xA3 then 0x3C, no overrun.
- div=16, send 0x11 and 0x22 without reading -> data=0x22, overrun pulses exactly 1 cycle, valid stays 1.
- div=16, send 0x7E with stop bit forced low, then hold low for 40 bits, then idle -> one frame_err pulse, valid stays 0. A following 0x81 is received correctly.
- div=16, 3-cycle low glitch on idle line -> no state progress past START, no outputs. With UART_RX_MAJORITY_EN, a 1-cycle mid-bit glitch inside 0xF0 still yields 0xF0.
- div=16, assert rst during data bit 4 of 0xC5 -> all outputs 0 the next cycle. The next full frame 0x5A is received correctly. Change baud_divider to 8 mid-frame -> the current byte is still decoded correctly at 16.
